// File: rtl/gci_std_display_refill_pkg.sv
// Shared state encoding and constants for the display FIFO refill controller.
// Optional underflow monitor is built only when GCI_STD_DISPLAY_REFILL_UNDERFLOW_EN is defined.
package gci_std_display_refill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_REQ   = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4
    } refill_state_t;

    localparam logic [15:0] UNDERFLOW_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/gci_std_display_refill_addr_gen.sv
// Frame address walker: loads base/length on start, advances one burst per completed burst,
// and wraps to the frame base with a one-cycle frame-end pulse after the final burst.
module gci_std_display_refill_addr_gen #(
    parameter int P_ADDR_N  = 32,
    parameter int P_FRAME_N = 24,
    parameter int P_BURST   = 8
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 load,
    input  logic                 advance,
    input  logic [P_ADDR_N-1:0]  base_addr,
    input  logic [P_FRAME_N-1:0] frame_beats,
    output logic [P_ADDR_N-1:0]  addr,
    output logic                 frame_end
);

    localparam logic [P_FRAME_N-1:0] BURST_BEATS = P_FRAME_N'(P_BURST);
    localparam logic [P_ADDR_N-1:0]  BURST_STEP  = P_ADDR_N'(P_BURST);

    logic [P_ADDR_N-1:0]  base_q;
    logic [P_FRAME_N-1:0] frame_q;
    logic [P_FRAME_N-1:0] remain;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            base_q    <= '0;
            frame_q   <= '0;
            addr      <= '0;
            remain    <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (load) begin
                base_q  <= base_addr;
                frame_q <= frame_beats;
                addr    <= base_addr;
                remain  <= frame_beats;
            end else if (advance) begin
                if (remain <= BURST_BEATS) begin
                    addr      <= base_q;
                    remain    <= frame_q;
                    frame_end <= 1'b1;
                end else begin
                    addr   <= addr + BURST_STEP;
                    remain <= remain - BURST_BEATS;
                end
            end
        end
    end

endmodule

// File: rtl/gci_std_display_fifo_refill_ctrl.sv
// Burst-refill controller keeping the scanout FIFO topped up from frame memory.
// Define GCI_STD_DISPLAY_REFILL_UNDERFLOW_EN to build the sticky underflow monitor.
module gci_std_display_fifo_refill_ctrl
    import gci_std_display_refill_pkg::*;
#(
    parameter int P_ADDR_N  = 32,
    parameter int P_DATA_N  = 16,
    parameter int P_DEPTH_N = 6,
    parameter int P_BURST   = 8,
    parameter int P_FRAME_N = 24
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iENABLE,
    input  logic [P_ADDR_N-1:0]  iBASE_ADDR,
    input  logic [P_FRAME_N-1:0] iFRAME_BEATS,
    output logic                 oMEM_REQ,
    output logic [P_ADDR_N-1:0]  oMEM_ADDR,
    input  logic                 iMEM_ACK,
    input  logic                 iMEM_VALID,
    input  logic [P_DATA_N-1:0]  iMEM_DATA,
    input  logic [P_DEPTH_N:0]   iFIFO_COUNT,
    output logic                 oFIFO_WR_EN,
    output logic [P_DATA_N-1:0]  oFIFO_WR_DATA,
    output logic                 oFIFO_REMOVE,
    input  logic                 iFIFO_RD_EN,
    input  logic                 iFIFO_EMPTY,
    output logic                 oBUSY,
    output logic                 oFRAME_END,
    output logic                 oUNDERFLOW,
    output logic [15:0]          oUNDERFLOW_CNT
);

    localparam int BEAT_W = (P_BURST > 1) ? $clog2(P_BURST) : 1;
    localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(P_BURST - 1);
    localparam logic [P_DEPTH_N+1:0] FIFO_SIZE   = (P_DEPTH_N+2)'(2 ** P_DEPTH_N);
    localparam logic [P_DEPTH_N+1:0] BURST_SPACE = (P_DEPTH_N+2)'(P_BURST);

    refill_state_t       state;
    logic [BEAT_W-1:0]   beat;
    logic [P_DEPTH_N+1:0] free_space;
    logic                start;
    logic                burst_done;

    // One extra bit keeps the subtraction from wrapping when the FIFO is full.
    assign free_space = FIFO_SIZE - {1'b0, iFIFO_COUNT};
    assign start      = (state == ST_IDLE) && iENABLE;
    assign burst_done = (state == ST_DATA) && iMEM_VALID && (beat == LAST_BEAT);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (iENABLE) state <= ST_ARM;
                ST_ARM: begin
                    if (!iENABLE)                       state <= ST_FLUSH;
                    else if (free_space >= BURST_SPACE) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (iMEM_ACK) begin
                        beat  <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (iMEM_VALID) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) state <= iENABLE ? ST_ARM : ST_FLUSH;
                    end
                end
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    gci_std_display_refill_addr_gen #(
        .P_ADDR_N  (P_ADDR_N),
        .P_FRAME_N (P_FRAME_N),
        .P_BURST   (P_BURST)
    ) u_addr_gen (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .load        (start),
        .advance     (burst_done),
        .base_addr   (iBASE_ADDR),
        .frame_beats (iFRAME_BEATS),
        .addr        (oMEM_ADDR),
        .frame_end   (oFRAME_END)
    );

    assign oMEM_REQ      = (state == ST_REQ);
    assign oFIFO_REMOVE  = (state == ST_FLUSH);
    assign oBUSY         = (state != ST_IDLE);
    assign oFIFO_WR_EN   = (state == ST_DATA) && iMEM_VALID;
    assign oFIFO_WR_DATA = oFIFO_WR_EN ? iMEM_DATA : '0;

`ifdef GCI_STD_DISPLAY_REFILL_UNDERFLOW_EN
    logic        underflow;
    logic [15:0] underflow_cnt;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (start) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if ((state != ST_IDLE) && iFIFO_RD_EN && iFIFO_EMPTY) begin
            underflow <= 1'b1;
            if (underflow_cnt != UNDERFLOW_CNT_MAX) underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    assign oUNDERFLOW     = underflow;
    assign oUNDERFLOW_CNT = underflow_cnt;
`else
    logic unused_monitor_inputs;
    assign unused_monitor_inputs = &{1'b0, iFIFO_RD_EN, iFIFO_EMPTY};
    assign oUNDERFLOW     = 1'b0;
    assign oUNDERFLOW_CNT = '0;
`endif

endmodule

// File: doc/gci_std_display_fifo_refill_ctrl.md
# gci_std_display_fifo_refill_ctrl

Burst-refill controller that keeps the display pixel sync FIFO topped up from frame memory during scanout. It watches the FIFO occupancy, issues fixed-length read bursts on the memory request/ack interface, and streams returned beats straight into the FIFO write port. It walks the frame buffer linearly and wraps at frame end. It is the sole writer of the FIFO and sits between the memory arbiter and the scanout FIFO.

## Interface
- P_ADDR_N, 32, memory word-address width
- P_DATA_N, 16, beat/FIFO data width
- P_DEPTH_N, 6, FIFO depth log2 (depth = 2^P_DEPTH_N); count port is P_DEPTH_N+1 bits
- P_BURST, 8, beats per burst; power of two, ≤ 2^P_DEPTH_N
- P_FRAME_N, 24, width of frame length in beats

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous, active-low reset
- iENABLE  in  1  level; scanout refill enabled
- iBASE_ADDR  in  P_ADDR_N  frame start word address, sampled on IDLE exit
- iFRAME_BEATS  in  P_FRAME_N  frame length in beats, sampled on IDLE exit, nonzero multiple of P_BURST
- oMEM_REQ  out  1  burst request
- oMEM_ADDR  out  P_ADDR_N  burst start address, valid with oMEM_REQ
- iMEM_ACK  in  1  request accepted
- iMEM_VALID  in  1  returned beat valid
- iMEM_DATA  in  P_DATA_N  returned beat
- iFIFO_COUNT  in  P_DEPTH_N+1  FIFO occupancy
- oFIFO_WR_EN  out  1  FIFO write strobe
- oFIFO_WR_DATA  out  P_DATA_N  FIFO write data
- oFIFO_REMOVE  out  1  one-cycle FIFO flush
- iFIFO_RD_EN  in  1  scanout read strobe (underflow monitor)
- iFIFO_EMPTY  in  1  FIFO empty (underflow monitor)
- oBUSY  out  1  state ≠ IDLE
- oFRAME_END  out  1  one-cycle pulse when the last burst of a frame completes
- oUNDERFLOW  out  1  sticky underflow flag
- oUNDERFLOW_CNT  out  16  underflow cycle count, saturating

## Operation
- States: IDLE, ARM, REQ, DATA, FLUSH.
- IDLE: if iENABLE, load addr←iBASE_ADDR, remain←iFRAME_BEATS, clear the underflow monitor, → ARM.
- ARM: if !iENABLE → FLUSH. Else if free = 2^P_DEPTH_N − iFIFO_COUNT ≥ P_BURST → REQ. Compute free in P_DEPTH_N+2 bits.
- REQ: oMEM_REQ=1, oMEM_ADDR=addr. Request is never retracted: iENABLE is ignored here. On iMEM_ACK, beat←0, → DATA.
- DATA: oFIFO_WR_EN = iMEM_VALID and oFIFO_WR_DATA = iMEM_DATA, combinational pass-through; beat++ per valid. On the P_BURST-th beat:
  - If remain ≤ P_BURST: addr←base, remain←frame beats, pulse oFRAME_END.
  - Else: addr += P_BURST, remain −= P_BURST, with modulo 2^P_ADDR_N wrap.
  - Next state: iENABLE ? ARM : FLUSH.
- FLUSH: oFIFO_REMOVE=1 for one cycle, → IDLE.
- iMEM_VALID outside DATA is ignored and never written.
- The FIFO cannot overflow, because the ARM check reserves a full burst of space.

## Timing
- Reset values: all outputs 0, state IDLE, addr/remain/beat 0.
- Reset asserted mid-burst returns to IDLE immediately. No FIFO remove is issued. Memory-side cleanup belongs to the arbiter.
- iENABLE rising edge → ARM next cycle → oMEM_REQ the following cycle, provided space is available.
- FIFO write lands at the edge ending the iMEM_VALID cycle. ARM, one cycle after the last beat, therefore sees the updated count.
- oMEM_REQ/oMEM_ADDR come from registered state/addr. An ACK in the first REQ cycle is legal: DATA starts the next cycle.
- Back-to-back bursts: minimum two cycles from last beat to next oMEM_REQ (DATA→ARM→REQ).
- oFRAME_END asserts the cycle after the final beat.

## Configuration
- Macro: GCI_STD_DISPLAY_REFILL_UNDERFLOW_EN.
- Defined: while oBUSY, every cycle with iFIFO_RD_EN && iFIFO_EMPTY sets oUNDERFLOW (sticky until the next IDLE exit) and increments oUNDERFLOW_CNT, saturating at 16'hFFFF.
- Undefined: ports are still present; outputs are tied to 0 and the inputs are ignored.

## Structure
- Shared package/include gci_std_display_refill_pkg: state encodings (IDLE=0, ARM=1, REQ=2, DATA=3, FLUSH=4, 3 bits) and the default macro guard.
- Sub-module gci_std_display_refill_addr_gen: holds addr/remain, load-on-start, advance/wrap on burst-done, and generates oFRAME_END.
- The FSM and underflow monitor stay in the top module.

## Test plan
All scenarios use P_DEPTH_N=6, P_BURST=8, base 0x1000, frame 32 beats.
- Reset: all outputs 0; oBUSY=0 with iENABLE held 0 → stays IDLE.
- Enable with count=0: oMEM_REQ with addr 0x1000 two cycles after enable; ACK, then 8 valids → 8 FIFO writes with matching data; next request at 0x1008.
- Four bursts: 4th completes → oFRAME_END one cycle; 5th request at 0x1000.
- Backpressure: count=57 holds ARM with no request; count=56 → oMEM_REQ next cycle.
- Disable after 3 beats of a burst: remaining 5 beats are still written, then oFIFO_REMOVE for one cycle, then IDLE with oBUSY=0. Disable during REQ: request held until ACK, burst completes, then flush.
- Underflow, with macro defined: 3 cycles of iFIFO_RD_EN && iFIFO_EMPTY → oUNDERFLOW=1, oUNDERFLOW_CNT=3; with the macro undefined both stay 0.
